// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save resolver: default geometry, FSM states
// and the chunk-count derivation.
package csa_pkg;

    localparam int DEF_WIDTH = 92;
    localparam int DEF_CHUNK = 23;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/csa_chunk_add.sv
// Combinational CHUNK-bit adder with carry in and carry out; one slice of the
// sequential carry-propagate resolver.
module csa_chunk_add #(
    parameter int CHUNK = 23
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/csa_resolve_seq.sv
// Sequential carry-propagate resolver: adds a captured (sum, carry) pair CHUNK
// bits per cycle with a registered ripple carry, result modulo 2^WIDTH.
module csa_resolve_seq
    import csa_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("csa_resolve_seq: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_t            state;
    state_t            state_next;
    logic              accept;
    logic [KW-1:0]     k;
    logic              cin;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [WIDTH-1:0]  result;
    logic [CHUNK-1:0]  a_slice;
    logic [CHUNK-1:0]  b_slice;
    logic [CHUNK-1:0]  slice_sum;
    logic              slice_cout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // in_ready is a function of state and rst only, never of the handshake inputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                accept   = in_valid && !rst;
                if (accept) begin
                    state_next = ADD;
                end
            end
            ADD: begin
                if (k == K_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        a_slice = op_a[32'(k) * CHUNK +: CHUNK];
        b_slice = op_b[32'(k) * CHUNK +: CHUNK];
    end

    csa_chunk_add #(
        .CHUNK (CHUNK)
    ) u_chunk_add (
        .a    (a_slice),
        .b    (b_slice),
        .cin  (cin),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Slices land in place in the result register; the top carry-out is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            k      <= '0;
            cin    <= 1'b0;
            result <= '0;
        end else if (accept) begin
            op_a <= in_sum;
            op_b <= in_carry;
            k    <= '0;
            cin  <= 1'b0;
        end else if (state == ADD) begin
            result[32'(k) * CHUNK +: CHUNK] <= slice_sum;
            cin <= slice_cout;
            k   <= (k == K_LAST) ? '0 : k + KW'(1);
        end
    end

    assign out_result = result;

endmodule

// File: tb/tb_csa_resolve_seq.sv
// Bench for csa_resolve_seq: cycle-level handshake/latency model with a result
// scoreboard, directed corner cases and randomized carry-save reductions.
module tb_csa_resolve_seq;

    localparam int W   = 92;
    localparam int NC  = 4;
    localparam int LAT = NC + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_sum = '0;
    logic [W-1:0] in_carry = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_result;

    csa_resolve_seq dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sum     (in_sum),
        .in_carry   (in_carry),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd92();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[W-1:0];
    endfunction

    // Reference model: one pair in flight, visible LAT cycles after acceptance,
    // held until the consumer takes it; reset discards it.
    bit           mon_en  = 1'b0;
    bit           pending = 1'b0;
    int           age     = 0;
    logic [W-1:0] exp_res = '0;

    always @(negedge clk) begin
        bit ev;
        bit er;
        if (mon_en) begin
            if (pending) age++;
            ev = pending && (age >= LAT);
            er = !pending && !rst;
            chk("out_valid", out_valid, ev);
            chk("in_ready", in_ready, er);
            if (ev) chk("out_result", out_result, exp_res);
            if (rst) begin
                pending = 1'b0;
            end else if (er && in_valid) begin
                pending = 1'b1;
                age     = 0;
                exp_res = in_sum + in_carry;
            end else if (ev && out_ready) begin
                pending = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_pair(input logic [W-1:0] s, input logic [W-1:0] c);
        bit ok;
        ok = 1'b0;
        in_sum   = s;
        in_carry = c;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat, output logic [W-1:0] res);
        lat = -1;
        res = '0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                res = out_result;
                break;
            end
        end
        if (lat < 0) chk("valid_timeout", 0, 1);
    endtask

    task automatic xact(input logic [W-1:0] s, input logic [W-1:0] c,
                        output logic [W-1:0] res, output int lat);
        out_ready = 1'b1;
        accept_pair(s, c);
        wait_valid(lat, res);
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] res;
        logic [W-1:0] r0;
        logic [W-1:0] s;
        logic [W-1:0] c;
        logic [W-1:0] ones;
        logic [W-1:0] total;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] rc;
        logic [W-1:0] rows[$];
        int lat;
        int cnt;

        ones = '1;

        // reset state
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        tick();
        rst = 1'b0;
        mon_en = 1'b1;

        // sanity
        xact(92'd5, 92'd7, res, lat);
        chk("sanity_result", res, 92'd12);
        chk("sanity_latency", lat, LAT);
        @(negedge clk);
        chk("sanity_valid_one_cycle", out_valid, 0);
        tick();

        // full ripple across every slice boundary
        xact(ones, 92'd1, res, lat);
        chk("ripple_result", res, 92'd0);
        s = {69'd0, 23'h7fffff};
        xact(s, 92'd1, res, lat);
        chk("ripple_one_slice", res, {68'd0, 1'b1, 23'd0});

        // backpressure with new data offered meanwhile
        out_ready = 1'b0;
        s = rnd92();
        c = rnd92();
        accept_pair(s, c);
        wait_valid(lat, r0);
        chk("bp_latency", lat, LAT);
        tick();
        in_valid = 1'b1;
        in_sum   = rnd92();
        in_carry = rnd92();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_result", out_result, r0);
            chk("bp_in_ready", in_ready, 0);
            tick();
        end
        chk("bp_result_value", r0, s + c);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("bp_released_idle", in_ready, 1);
        tick();

        // reset during the second ADD cycle
        accept_pair(92'h1111, 92'h2222);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rst_add_no_valid", out_valid, 0);
        end
        tick();
        xact(92'h1234, 92'h4321, res, lat);
        chk("after_rst_result", res, 92'h5555);

        // rst and in_valid together: nothing accepted
        in_sum   = 92'd99;
        in_carry = 92'd1;
        in_valid = 1'b1;
        rst      = 1'b1;
        @(negedge clk);
        chk("rst_wins_ready", in_ready, 0);
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_wins_idle", in_ready, 1);
        tick();

        // reset while DONE drops the result and zeroes out_result
        out_ready = 1'b0;
        accept_pair(92'hABC, 92'hDEF);
        wait_valid(lat, res);
        chk("done_rst_pre", res, 92'h18AB);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("done_rst_valid", out_valid, 0);
        chk("done_rst_result", out_result, 0);
        tick();
        out_ready = 1'b1;

        // back-to-back acceptances
        in_valid = 1'b1;
        cnt = 0;
        for (int j = 0; j < 20; j++) begin
            bit ok;
            ok = 1'b0;
            in_sum   = rnd92();
            in_carry = rnd92();
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                cnt++;
                if (in_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) chk("b2b_timeout", 0, 1);
            if (j > 0) chk("b2b_spacing", cnt, NC + 2);
            cnt = 0;
            tick();
        end
        in_valid = 1'b0;
        wait_valid(lat, res);
        tick();

        // end-to-end: 92 rows reduced 3:2 to a carry-save pair, then resolved
        for (int t = 0; t < 500; t++) begin
            rows.delete();
            total = '0;
            for (int r = 0; r < 92; r++) begin
                ra = (t < 3) ? ones : rnd92();
                rows.push_back(ra);
                total = total + ra;
            end
            while (rows.size() > 2) begin
                ra = rows.pop_front();
                rb = rows.pop_front();
                rc = rows.pop_front();
                rows.push_back(ra ^ rb ^ rc);
                rows.push_back(((ra & rb) | (ra & rc) | (rb & rc)) << 1);
            end
            xact(rows[0], rows[1], res, lat);
            chk("e2e_result", res, total);
        end

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
